z_chan_mux: RTL and testbench

- Registered N-channel, W-bit selector; parametrised successor of the basic 2:1 signal mux.
- Channel changes go through a valid/ready request handshake.
- Each switch is followed by a programmable blanking interval, so downstream photon counters never see a partial or glitched switchover.
- Sits between the detector front-end channels and the counting/timestamp logic.

---
 rtl/z_chan_mux.sv | 172 +++++++++++++++++
 tb/tb_z_chan_mux.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z_chan_mux.sv
// z_chan_mux: registered N_CH-channel, W-bit selector.
// Channel switches use a valid/ready request handshake.
// After each switch the output is blanked for BLANK_CYC cycles, so
// downstream photon counters never see a partial switchover.
//
// Optional build macro: ZCHAN_MUX_SYNC_EN
//   When defined, every iSig bit passes through a 2-flop synchronizer
//   before selection. This gives 3-cycle data latency. Handshake and
//   blanking timing are unchanged, measured at the selector stage.
//   When undefined, iSig must be synchronous to iClk and latency is 1 cycle.
//
// State  | meaning
// -------+----------------------------------------------------------------
// RUN    | oSig tracks the active channel; switch requests are accepted
// BLANK  | switch in progress; outputs held at 0, cnt counts down to 0

module z_chan_mux #(
  parameter int N_CH      = 4,
  parameter int W         = 1,
  parameter int SEL_W     = 2,
  parameter int BLANK_CYC = 4,
  parameter int RST_SEL   = 0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [N_CH*W-1:0] iSig,
  input  logic [SEL_W-1:0]  iSel,
  input  logic              iSelVld,
  output logic              oSelRdy,
  output logic              oSelAck,
  output logic              oSelErr,
  output logic [SEL_W-1:0]  oCurSel,
  output logic [W-1:0]      oSig,
  output logic              oVld
);

  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } stateE;

  localparam logic [SEL_W-1:0] RstSel  = SEL_W'(RST_SEL);
  localparam logic [SEL_W:0]   NumCh   = (SEL_W+1)'(N_CH);
  // The counter is loaded with BLANK_CYC-1 because the acceptance edge
  // already counts as the first blanked cycle.
  localparam logic [7:0]       BlankLd = (BLANK_CYC > 0) ? 8'(BLANK_CYC - 1) : 8'd0;

  logic [N_CH*W-1:0] selData;

  stateE            state, stateNx;
  logic [7:0]       cnt, cntNx;
  logic [SEL_W-1:0] pend, pendNx;
  logic [SEL_W-1:0] curSel, curSelNx;
  logic [W-1:0]     sigR, sigNx;
  logic             vldR, vldNx;
  logic             ackR, ackNx;
  logic             errR, errNx;

`ifdef ZCHAN_MUX_SYNC_EN
  logic [N_CH*W-1:0] syncMeta;
  logic [N_CH*W-1:0] syncOut;

  // Two-flop synchronizer on every channel bit ahead of the selector.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      syncMeta <= '0;
      syncOut  <= '0;
    end else begin
      syncMeta <= iSig;
      syncOut  <= syncMeta;
    end
  end

  assign selData = syncOut;
`else
  assign selData = iSig;
`endif

  // Returns the W-bit slice of channel idx.
  // An out-of-range index yields 0; that case is never used for output data.
  function automatic logic [W-1:0] sliceCh(input logic [N_CH*W-1:0] data,
                                           input logic [SEL_W-1:0]  idx);
    logic [W-1:0] res;
    res = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) res = data[k*W +: W];
    end
    return res;
  endfunction

  // Next-state and next-output decode for the switch sequencer.
  always_comb begin
    stateNx  = state;
    cntNx    = cnt;
    pendNx   = pend;
    curSelNx = curSel;
    sigNx    = sliceCh(selData, curSel);
    vldNx    = 1'b1;
    ackNx    = 1'b0;
    errNx    = 1'b0;
    case (state)
      RUN: begin
        if (iSelVld) begin
          if ({1'b0, iSel} >= NumCh) begin
            errNx = 1'b1;
          end else if (iSel == curSel) begin
            ackNx = 1'b1;
          end else if (BLANK_CYC == 0) begin
            curSelNx = iSel;
            sigNx    = sliceCh(selData, iSel);
            ackNx    = 1'b1;
          end else begin
            stateNx = BLANK;
            pendNx  = iSel;
            cntNx   = BlankLd;
            sigNx   = '0;
            vldNx   = 1'b0;
          end
        end
      end
      BLANK: begin
        if (cnt == 8'd0) begin
          stateNx  = RUN;
          curSelNx = pend;
          sigNx    = sliceCh(selData, pend);
          ackNx    = 1'b1;
        end else begin
          cntNx = cnt - 8'd1;
          sigNx = '0;
          vldNx = 1'b0;
        end
      end
      default: begin
        stateNx = RUN;
        sigNx   = '0;
        vldNx   = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  // Reset aborts any switch that is in flight.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= RUN;
      cnt    <= '0;
      pend   <= RstSel;
      curSel <= RstSel;
      sigR   <= '0;
      vldR   <= 1'b0;
      ackR   <= 1'b0;
      errR   <= 1'b0;
    end else begin
      state  <= stateNx;
      cnt    <= cntNx;
      pend   <= pendNx;
      curSel <= curSelNx;
      sigR   <= sigNx;
      vldR   <= vldNx;
      ackR   <= ackNx;
      errR   <= errNx;
    end
  end

  assign oSelRdy = (state == RUN);
  assign oSelAck = ackR;
  assign oSelErr = errR;
  assign oCurSel = curSel;
  assign oSig    = sigR;
  assign oVld    = vldR;

endmodule

// File: tb/tb_z_chan_mux.sv
// Testbench for z_chan_mux. It runs two instances side by side:
//   dutA: N_CH=4, W=1, SEL_W=3, BLANK_CYC=4, RST_SEL=0
//   dutB: N_CH=3, W=2, SEL_W=2, BLANK_CYC=0, RST_SEL=1
// A reference model checks both instances on every cycle. The model tracks
// each switch as "completes BLANK_CYC cycles after acceptance".

module tb_z_chan_mux;

  logic iClk = 1'b0;
  logic iRst = 1'b0;

  logic [3:0] sigA    = '0;
  logic [2:0] selA    = '0;
  logic       selVldA = 1'b0;
  logic       selRdyA, selAckA, selErrA, vldA;
  logic [2:0] curSelA;
  logic [0:0] sigOutA;

  logic [5:0] sigB    = '0;
  logic [1:0] selB    = '0;
  logic       selVldB = 1'b0;
  logic       selRdyB, selAckB, selErrB, vldB;
  logic [1:0] curSelB;
  logic [1:0] sigOutB;

  always #5 iClk = ~iClk;

  z_chan_mux #(.N_CH(4), .W(1), .SEL_W(3), .BLANK_CYC(4), .RST_SEL(0)) dutA (
    .iClk(iClk), .iRst(iRst), .iSig(sigA), .iSel(selA), .iSelVld(selVldA),
    .oSelRdy(selRdyA), .oSelAck(selAckA), .oSelErr(selErrA),
    .oCurSel(curSelA), .oSig(sigOutA), .oVld(vldA)
  );

  z_chan_mux #(.N_CH(3), .W(2), .SEL_W(2), .BLANK_CYC(0), .RST_SEL(1)) dutB (
    .iClk(iClk), .iRst(iRst), .iSig(sigB), .iSel(selB), .iSelVld(selVldB),
    .oSelRdy(selRdyB), .oSelAck(selAckB), .oSelErr(selErrB),
    .oCurSel(curSelB), .oSig(sigOutB), .oVld(vldB)
  );

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  int pN[2] = '{4, 3};
  int pW[2] = '{1, 2};
  int pB[2] = '{4, 0};
  int pR[2] = '{0, 1};

  int mCur[2], mPend[2], mDone[2], mBusy[2];
  int mSig[2], mVld[2], mAck[2], mErr[2];
  int h1[2], h2[2];

  typedef struct {
    logic [3:0] sig;
    logic [2:0] sel;
    logic       sv;
    logic       eVld;
    logic       eSig;
    logic       eAck;
    logic       eErr;
    logic [2:0] eCur;
    logic       eRdy;
  } vecT;

  vecT tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sliceOf(input int data, input int idx, input int w);
    return (data >> (idx * w)) & ((1 << w) - 1);
  endfunction

  function automatic void modelReset(input int i);
    mCur[i]  = pR[i];
    mPend[i] = pR[i];
    mDone[i] = 0;
    mBusy[i] = 0;
    mSig[i]  = 0;
    mVld[i]  = 0;
    mAck[i]  = 0;
    mErr[i]  = 0;
    h1[i]    = 0;
    h2[i]    = 0;
  endfunction

  function automatic void modelEdge(input int i, input int sig, input int sel, input int sv);
    int d;
`ifdef ZCHAN_MUX_SYNC_EN
    d     = h2[i];
    h2[i] = h1[i];
    h1[i] = sig;
`else
    d = sig;
`endif
    mAck[i] = 0;
    mErr[i] = 0;
    if (mBusy[i] != 0) begin
      if (cyc == mDone[i]) begin
        mBusy[i] = 0;
        mCur[i]  = mPend[i];
        mAck[i]  = 1;
        mVld[i]  = 1;
        mSig[i]  = sliceOf(d, mCur[i], pW[i]);
      end else begin
        mVld[i] = 0;
        mSig[i] = 0;
      end
    end else begin
      mVld[i] = 1;
      mSig[i] = sliceOf(d, mCur[i], pW[i]);
      if (sv != 0) begin
        if (sel >= pN[i]) begin
          mErr[i] = 1;
        end else if (sel == mCur[i]) begin
          mAck[i] = 1;
        end else if (pB[i] == 0) begin
          mCur[i] = sel;
          mAck[i] = 1;
          mSig[i] = sliceOf(d, sel, pW[i]);
        end else begin
          mBusy[i] = 1;
          mPend[i] = sel;
          mDone[i] = cyc + pB[i];
          mVld[i]  = 0;
          mSig[i]  = 0;
        end
      end
    end
  endfunction

  task automatic checkModel();
    chk("A.oSig",    int'(sigOutA), mSig[0]);
    chk("A.oVld",    int'(vldA),    mVld[0]);
    chk("A.oSelRdy", int'(selRdyA), 1 - mBusy[0]);
    chk("A.oSelAck", int'(selAckA), mAck[0]);
    chk("A.oSelErr", int'(selErrA), mErr[0]);
    chk("A.oCurSel", int'(curSelA), mCur[0]);
    chk("B.oSig",    int'(sigOutB), mSig[1]);
    chk("B.oVld",    int'(vldB),    mVld[1]);
    chk("B.oSelRdy", int'(selRdyB), 1 - mBusy[1]);
    chk("B.oSelAck", int'(selAckB), mAck[1]);
    chk("B.oSelErr", int'(selErrB), mErr[1]);
    chk("B.oCurSel", int'(curSelB), mCur[1]);
  endtask

  // Advance one clock: update the model at the edge, check 1 time unit later,
  // and return at the falling edge, ready for new stimulus.
  task automatic tick();
    @(posedge iClk);
    if (iRst) begin
      modelReset(0);
      modelReset(1);
    end else begin
      modelEdge(0, int'(sigA), int'(selA), int'(selVldA));
      modelEdge(1, int'(sigB), int'(selB), int'(selVldB));
    end
    cyc++;
    #1;
    checkModel();
    @(negedge iClk);
  endtask

  task automatic assertRst();
    iRst = 1'b1;
    #1;
    modelReset(0);
    modelReset(1);
    checkModel();
  endtask

  initial begin
    //         sig      sel   sv    vld   sig   ack   err   cur   rdy
    tbl[0]  = '{4'b0001, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[1]  = '{4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[2]  = '{4'b0001, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[3]  = '{4'b0100, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[4]  = '{4'b0100, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[5]  = '{4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[6]  = '{4'b0100, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1};
    tbl[7]  = '{4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1};
    tbl[8]  = '{4'b0100, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1};
    tbl[9]  = '{4'b0000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1};
    tbl[10] = '{4'b1111, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1};
    tbl[11] = '{4'b1011, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1};

    // Reset values, then release.
    @(negedge iClk);
    assertRst();
    chk("rst.A.oCurSel", int'(curSelA), 0);
    chk("rst.B.oCurSel", int'(curSelB), 1);
    chk("rst.A.oSelRdy", int'(selRdyA), 1);
    chk("rst.A.oVld",    int'(vldA),    0);
    tick();
    iRst = 1'b0;
    tick();
    chk("rel.A.oVld", int'(vldA), 1);
    chk("rel.B.oVld", int'(vldB), 1);

    // Directed table on dutA: blanking switch, ignored request, same-channel, errors.
    for (int r = 0; r < 12; r++) begin
      sigA    = tbl[r].sig;
      selA    = tbl[r].sel;
      selVldA = tbl[r].sv;
      tick();
      chk($sformatf("tbl%0d.oVld", r),    int'(vldA),    int'(tbl[r].eVld));
`ifndef ZCHAN_MUX_SYNC_EN
      chk($sformatf("tbl%0d.oSig", r),    int'(sigOutA), int'(tbl[r].eSig));
`endif
      chk($sformatf("tbl%0d.oSelAck", r), int'(selAckA), int'(tbl[r].eAck));
      chk($sformatf("tbl%0d.oSelErr", r), int'(selErrA), int'(tbl[r].eErr));
      chk($sformatf("tbl%0d.oCurSel", r), int'(curSelA), int'(tbl[r].eCur));
      chk($sformatf("tbl%0d.oSelRdy", r), int'(selRdyA), int'(tbl[r].eRdy));
    end
    selVldA = 1'b0;

    // Reset two cycles into a blanking switch toward channel 3.
    selA    = 3'd3;
    selVldA = 1'b1;
    tick();
    selVldA = 1'b0;
    tick();
    tick();
    assertRst();
    chk("abort.oVld",    int'(vldA),    0);
    chk("abort.oSig",    int'(sigOutA), 0);
    chk("abort.oSelRdy", int'(selRdyA), 1);
    chk("abort.oSelAck", int'(selAckA), 0);
    chk("abort.oCurSel", int'(curSelA), 0);
    tick();
    iRst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort.noAck", int'(selAckA), 0);
      chk("abort.cur",   int'(curSelA), 0);
    end

    // dutB with zero blanking: switch 1->0, then 0->1, then an invalid index.
    sigB    = 6'b10_01_11;
    selB    = 2'd0;
    selVldB = 1'b1;
    tick();
    chk("b0.oSelAck", int'(selAckB), 1);
    chk("b0.oCurSel", int'(curSelB), 0);
    chk("b0.oVld",    int'(vldB),    1);
`ifndef ZCHAN_MUX_SYNC_EN
    chk("b0.oSig",    int'(sigOutB), 3);
`endif
    sigB = 6'b00_10_01;
    selB = 2'd1;
    tick();
    chk("b1.oSelAck", int'(selAckB), 1);
    chk("b1.oCurSel", int'(curSelB), 1);
    chk("b1.oVld",    int'(vldB),    1);
`ifndef ZCHAN_MUX_SYNC_EN
    chk("b1.oSig",    int'(sigOutB), 2);
`endif
    selB = 2'd3;
    tick();
    chk("b3.oSelErr", int'(selErrB), 1);
    chk("b3.oSelAck", int'(selAckB), 0);
    chk("b3.oCurSel", int'(curSelB), 1);
    selVldB = 1'b0;
    tick();

    // Randomized traffic on both instances, with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      iRst    = 1'b0;
      sigA    = 4'($urandom);
      sigB    = 6'($urandom);
      selA    = 3'($urandom_range(0, 7));
      selB    = 2'($urandom_range(0, 3));
      selVldA = ($urandom_range(0, 3) == 0);
      selVldB = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) assertRst();
      tick();
    end
    iRst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
